// File: rtl/unified_memory_arbiter.sv
// Purpose: shares one single-port memory between instruction fetch and data load/store, with data priority and a fetch starvation guard.
// Latency: request sampled in cycle 0, mem_req from cycle 1 until mem_ack (cycle k), requester ack in cycle k+1; minimum 2 cycles.
// Backpressure: requesters hold their request until ack; stall_o freezes the pipeline while any request is unacknowledged.
module unified_memory_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_if_req,
   input  logic [ADDR_WIDTH-1:0] i_if_addr,
   output logic                  o_if_ack,
   output logic [DATA_WIDTH-1:0] o_if_rdata,
   input  logic                  i_d_req,
   input  logic                  i_d_we,
   input  logic [ADDR_WIDTH-1:0] i_d_addr,
   input  logic [DATA_WIDTH-1:0] i_d_wdata,
   output logic                  o_d_ack,
   output logic [DATA_WIDTH-1:0] o_d_rdata,
   output logic                  o_mem_req,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   input  logic                  i_mem_ack,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   output logic                  o_stall,
   output logic                  o_err
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_owner_d;      // 1: data port owns the current access
   logic [SW-1:0]         r_starve_cnt;
   logic [TW-1:0]         r_tcnt;
   logic                  r_mem_req;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic                  r_if_ack;
   logic                  r_d_ack;
   logic [DATA_WIDTH-1:0] r_if_rdata;
   logic [DATA_WIDTH-1:0] r_d_rdata;
   logic                  r_err;

   logic                  w_starved;
   logic                  w_grant_d;

   // Fetch is forced only when it has been passed over STARVE_LIMIT times in a row
   assign w_starved = i_if_req & (r_starve_cnt == STARVE_MAX);
   assign w_grant_d = i_d_req & ~w_starved;

   // Arbitration FSM: IDLE picks a winner, BUSY waits for memory or timeout, RESP pulses the owner's ack
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_owner_d    <= 1'b0;
         r_starve_cnt <= '0;
         r_tcnt       <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_if_ack     <= 1'b0;
         r_d_ack      <= 1'b0;
         r_if_rdata   <= '0;
         r_d_rdata    <= '0;
         r_err        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_d_req | i_if_req) begin
                  r_state   <= S_BUSY;
                  r_mem_req <= 1'b1;
                  r_tcnt    <= '0;
                  if (w_grant_d) begin
                     r_owner_d   <= 1'b1;
                     r_mem_we    <= i_d_we;
                     r_mem_addr  <= i_d_addr;
                     r_mem_wdata <= i_d_wdata;
                     // Only grants that actually pass over a waiting fetch count toward starvation
                     if (i_if_req && (r_starve_cnt != STARVE_MAX))
                        r_starve_cnt <= r_starve_cnt + SW'(1);
                  end else begin
                     r_owner_d    <= 1'b0;
                     r_mem_we     <= 1'b0;
                     r_mem_addr   <= i_if_addr;
                     r_mem_wdata  <= '0;
                     r_starve_cnt <= '0;
                  end
               end
            end
            S_BUSY: begin
               if (i_mem_ack) begin
                  r_state   <= S_RESP;
                  r_mem_req <= 1'b0;
                  if (r_owner_d) begin
                     r_d_ack <= 1'b1;
                     // Stores leave the last load data visible
                     if (!r_mem_we)
                        r_d_rdata <= i_mem_rdata;
                  end else begin
                     r_if_ack   <= 1'b1;
                     r_if_rdata <= i_mem_rdata;
                  end
               end else if (r_tcnt == TCNT_LAST) begin
                  // Memory never answered: complete the access as aborted with zero data
                  r_state   <= S_RESP;
                  r_mem_req <= 1'b0;
                  r_err     <= 1'b1;
                  if (r_owner_d) begin
                     r_d_ack   <= 1'b1;
                     r_d_rdata <= '0;
                  end else begin
                     r_if_ack   <= 1'b1;
                     r_if_rdata <= '0;
                  end
               end else begin
                  r_tcnt <= r_tcnt + TW'(1);
               end
            end
            S_RESP: begin
               r_if_ack <= 1'b0;
               r_d_ack  <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_if_ack    = r_if_ack;
   assign o_if_rdata  = r_if_rdata;
   assign o_d_ack     = r_d_ack;
   assign o_d_rdata   = r_d_rdata;
   assign o_mem_req   = r_mem_req;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_err       = r_err;
   assign o_stall     = (i_if_req & ~r_if_ack) | (i_d_req & ~r_d_ack);

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Purpose: scoreboard bench for unified_memory_arbiter; stimulus pushes expected acks and memory transactions, a monitor pops and compares.
// Latency: expected ack cycles are hand-computed offsets from the cycle a request is first driven.
// Backpressure: bench requesters hold req until ack; a memory responder acks after a programmable number of BUSY cycles.
module tb_unified_memory_arbiter;

   logic        clk;
   logic        i_reset;
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic        o_if_ack;
   logic [31:0] o_if_rdata;
   logic        i_d_req;
   logic        i_d_we;
   logic [31:0] i_d_addr;
   logic [31:0] i_d_wdata;
   logic        o_d_ack;
   logic [31:0] o_d_rdata;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;
   logic        o_stall;
   logic        o_err;

   unified_memory_arbiter #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .STARVE_LIMIT  (4),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .i_clk      (clk),
      .i_reset    (i_reset),
      .i_if_req   (i_if_req),
      .i_if_addr  (i_if_addr),
      .o_if_ack   (o_if_ack),
      .o_if_rdata (o_if_rdata),
      .i_d_req    (i_d_req),
      .i_d_we     (i_d_we),
      .i_d_addr   (i_d_addr),
      .i_d_wdata  (i_d_wdata),
      .o_d_ack    (o_d_ack),
      .o_d_rdata  (o_d_rdata),
      .o_mem_req  (o_mem_req),
      .o_mem_we   (o_mem_we),
      .o_mem_addr (o_mem_addr),
      .o_mem_wdata(o_mem_wdata),
      .i_mem_ack  (i_mem_ack),
      .i_mem_rdata(i_mem_rdata),
      .o_stall    (o_stall),
      .o_err      (o_err)
   );

   typedef struct {
      logic        is_d;
      logic [31:0] rdata;
      int          cyc;
      logic        err;
   } ack_exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_exp_t;

   ack_exp_t    ack_q[$];
   mem_exp_t    mem_q[$];
   logic [31:0] bmem [logic [31:0]];

   int cyc;
   int vectors;
   int miscompares;
   int ack_delay;   // BUSY cycle index (from 0) in which memory acks; -1 = never
   int busy_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter: during cycle c (after its opening edge) cyc holds c
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic exp_access(input logic is_d, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int lat, input logic err);
      ack_exp_t a;
      mem_exp_t m;
      a.is_d = is_d; a.rdata = rdata; a.cyc = cyc + lat; a.err = err;
      m.we = we; m.addr = addr; m.wdata = wdata;
      ack_q.push_back(a);
      mem_q.push_back(m);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      bit done;
      done      = 1'b0;
      i_d_we    = we;
      i_d_addr  = addr;
      i_d_wdata = wdata;
      i_d_req   = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(posedge clk);
         #1;
         if (o_d_ack) done = 1'b1;
      end
      i_d_req = 1'b0;
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL d_ack_timeout: got no d_ack in 100 cycles, expected d_ack for addr 0x%0h", addr);
      end
   endtask

   task automatic f_access(input logic [31:0] addr);
      bit done;
      done      = 1'b0;
      i_if_addr = addr;
      i_if_req  = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(posedge clk);
         #1;
         if (o_if_ack) done = 1'b1;
      end
      i_if_req = 1'b0;
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL if_ack_timeout: got no if_ack in 100 cycles, expected if_ack for addr 0x%0h", addr);
      end
   endtask

   task automatic check_ack(input logic is_d);
      ack_exp_t e;
      if (ack_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL ack_unexpected: got ack on port is_d=%0d at cycle %0d, expected none", is_d, cyc);
      end else begin
         e = ack_q.pop_front();
         chk("ack_port", 32'(is_d), 32'(e.is_d));
         chk("ack_cycle", cyc, e.cyc);
         chk("ack_rdata", is_d ? o_d_rdata : o_if_rdata, e.rdata);
         chk("ack_err", 32'(o_err), 32'(e.err));
      end
   endtask

   // Memory responder: acks in BUSY cycle ack_delay, reading/writing the bench memory
   initial begin
      i_mem_ack   = 1'b0;
      i_mem_rdata = 32'h0;
      busy_n      = -1;
      forever begin
         @(posedge clk);
         #1;
         if (o_mem_req) begin
            busy_n = (busy_n < 0) ? 0 : busy_n + 1;
            if (ack_delay >= 0 && busy_n == ack_delay) begin
               i_mem_ack   = 1'b1;
               i_mem_rdata = bmem.exists(o_mem_addr) ? bmem[o_mem_addr] : 32'h0;
               if (o_mem_we) bmem[o_mem_addr] = o_mem_wdata;
            end else begin
               i_mem_ack   = 1'b0;
               i_mem_rdata = 32'hCAFE_0000;
            end
         end else begin
            busy_n      = -1;
            i_mem_ack   = 1'b0;
            i_mem_rdata = 32'hCAFE_0000;
         end
      end
   end

   // Monitor: stall every cycle, acks against the ack queue, memory port against the memory queue
   initial begin
      logic     prev_req;
      mem_exp_t cur;
      prev_req = 1'b0;
      cur.we = 1'b0; cur.addr = 32'h0; cur.wdata = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         chk("stall_o", 32'(o_stall), 32'((i_if_req & ~o_if_ack) | (i_d_req & ~o_d_ack)));
         if (o_if_ack) check_ack(1'b0);
         if (o_d_ack)  check_ack(1'b1);
         if (o_mem_req && !prev_req) begin
            if (mem_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL mem_unexpected: got mem_req addr 0x%0h at cycle %0d, expected none", o_mem_addr, cyc);
            end else begin
               cur = mem_q.pop_front();
               chk("mem_we", 32'(o_mem_we), 32'(cur.we));
               chk("mem_addr", o_mem_addr, cur.addr);
               chk("mem_wdata", o_mem_wdata, cur.wdata);
            end
         end else if (o_mem_req) begin
            chk("mem_we_stable", 32'(o_mem_we), 32'(cur.we));
            chk("mem_addr_stable", o_mem_addr, cur.addr);
            chk("mem_wdata_stable", o_mem_wdata, cur.wdata);
         end
         prev_req = o_mem_req;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus
   initial begin
      mem_exp_t m;
      vectors     = 0;
      miscompares = 0;
      ack_delay   = 0;
      i_reset     = 1'b1;
      i_if_req    = 1'b0;
      i_if_addr   = 32'h0;
      i_d_req     = 1'b0;
      i_d_we      = 1'b0;
      i_d_addr    = 32'h0;
      i_d_wdata   = 32'h0;
      bmem[32'h10] = 32'h0050_0093;
      bmem[32'h40] = 32'h1111_2222;
      bmem[32'h44] = 32'h0BAD_F00D;

      idle(3);
      chk("rst_mem_req", 32'(o_mem_req), 32'h0);
      chk("rst_mem_we", 32'(o_mem_we), 32'h0);
      chk("rst_mem_addr", o_mem_addr, 32'h0);
      chk("rst_mem_wdata", o_mem_wdata, 32'h0);
      chk("rst_if_ack", 32'(o_if_ack), 32'h0);
      chk("rst_d_ack", 32'(o_d_ack), 32'h0);
      chk("rst_if_rdata", o_if_rdata, 32'h0);
      chk("rst_d_rdata", o_d_rdata, 32'h0);
      chk("rst_err", 32'(o_err), 32'h0);
      i_reset = 1'b0;
      idle(1);

      // Fetch only, memory acks in the first BUSY cycle: if_ack in cycle 2
      ack_delay = 0;
      exp_access(1'b0, 1'b0, 32'h10, 32'h0, 32'h0050_0093, 2, 1'b0);
      f_access(32'h10);
      idle(2);

      // Contention: data load first (ack cycle 2), fetch next (ack cycle 5)
      exp_access(1'b1, 1'b0, 32'h40, 32'h0, 32'h1111_2222, 2, 1'b0);
      exp_access(1'b0, 1'b0, 32'h10, 32'h0, 32'h0050_0093, 5, 1'b0);
      fork
         d_access(1'b0, 32'h40, 32'h0);
         f_access(32'h10);
      join
      idle(2);

      // Store with 3 wait cycles: mem_req cycles 1..4, d_ack cycle 5, d_rdata keeps last load
      ack_delay = 3;
      exp_access(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h1111_2222, 5, 1'b0);
      d_access(1'b1, 32'h20, 32'hDEAD_BEEF);
      idle(2);

      // Starvation: four data grants, then forced fetch, then counter reset lets data win again
      ack_delay = 0;
      exp_access(1'b1, 1'b0, 32'h40, 32'h0, 32'h1111_2222,  2, 1'b0);
      exp_access(1'b1, 1'b0, 32'h40, 32'h0, 32'h1111_2222,  5, 1'b0);
      exp_access(1'b1, 1'b0, 32'h40, 32'h0, 32'h1111_2222,  8, 1'b0);
      exp_access(1'b1, 1'b0, 32'h40, 32'h0, 32'h1111_2222, 11, 1'b0);
      exp_access(1'b0, 1'b0, 32'h10, 32'h0, 32'h0050_0093, 14, 1'b0);
      exp_access(1'b1, 1'b0, 32'h40, 32'h0, 32'h1111_2222, 17, 1'b0);
      exp_access(1'b0, 1'b0, 32'h10, 32'h0, 32'h0050_0093, 20, 1'b0);
      fork
         begin
            repeat (5) d_access(1'b0, 32'h40, 32'h0);
         end
         begin
            repeat (2) f_access(32'h10);
         end
      join
      idle(2);

      // Timeout: 8 BUSY cycles without mem_ack, aborted load acks in cycle 9 with zero data
      ack_delay = -1;
      exp_access(1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 9, 1'b1);
      d_access(1'b0, 32'h40, 32'h0);
      idle(4);
      chk("err_sticky", 32'(o_err), 32'h1);

      // Reset during cycle 2 of a load: access abandoned, then the held request completes
      ack_delay = 3;
      m.we = 1'b0; m.addr = 32'h44; m.wdata = 32'h0;
      mem_q.push_back(m);
      exp_access(1'b1, 1'b0, 32'h44, 32'h0, 32'h0BAD_F00D, 8, 1'b0);
      fork
         d_access(1'b0, 32'h44, 32'h0);
         begin
            idle(2);
            i_reset = 1'b1;
            idle(1);
            chk("rstbusy_mem_req", 32'(o_mem_req), 32'h0);
            chk("rstbusy_d_ack", 32'(o_d_ack), 32'h0);
            chk("rstbusy_err", 32'(o_err), 32'h0);
            chk("rstbusy_d_rdata", o_d_rdata, 32'h0);
            i_reset = 1'b0;
         end
      join
      idle(3);

      chk("ack_q_drained", ack_q.size(), 32'h0);
      chk("mem_q_drained", mem_q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
